// File: rtl/tlb_walk_if.sv
// Lookup/response and page-table-walk signal bundle for the data TLB.
// The TLB is the slave side; the MEM stage and walker together form the master side.
interface tlb_walk_if #(
    parameter int VA_W  = 32,
    parameter int PA_W  = 20,
    parameter int OFF_W = 12
);
    localparam int VPN_W = VA_W - OFF_W;
    localparam int PPN_W = PA_W - OFF_W;

    // Handshakes: a lookup is taken when req_valid=1 and stall=0 at a clock edge,
    // and its result shows as resp_valid for one cycle. A walk is offered by
    // holding ptw_req=1 until the edge where ptw_ack=1; that edge completes it.
    logic             req_valid;
    logic [VA_W-1:0]  req_vaddr;
    logic             req_write;
    logic             resp_valid;
    logic [PA_W-1:0]  resp_paddr;
    logic             resp_fault;
    logic             stall;
    logic             ptw_req;
    logic [VPN_W-1:0] ptw_vpn;
    logic             ptw_ack;
    logic [PPN_W-1:0] ptw_ppn;
    logic             ptw_writable;
    logic             ptw_fault;

    modport slave (
        input  req_valid, req_vaddr, req_write, ptw_ack, ptw_ppn, ptw_writable, ptw_fault,
        output resp_valid, resp_paddr, resp_fault, stall, ptw_req, ptw_vpn
    );

    modport master (
        output req_valid, req_vaddr, req_write, ptw_ack, ptw_ppn, ptw_writable, ptw_fault,
        input  resp_valid, resp_paddr, resp_fault, stall, ptw_req, ptw_vpn
    );
endinterface

// File: rtl/tlb_walk.sv
// Fully-associative data TLB with saturating-age LRU replacement, flush support,
// and a two-state miss handler that requests page-table walks and refills.
module tlb_walk #(
    parameter int N     = 16,
    parameter int VA_W  = 32,
    parameter int PA_W  = 20,
    parameter int OFF_W = 12,
    parameter int AGE_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode,
    input  logic                  flush_all,
    input  logic                  flush_vpn_en,
    input  logic [VA_W-OFF_W-1:0] flush_vpn,
    tlb_walk_if.slave             bus,
    output logic                  dbg_state
);
    localparam int VPN_W = VA_W - OFF_W;
    localparam int PPN_W = PA_W - OFF_W;
    localparam int IDX_W = $clog2(N);
    localparam logic [AGE_W-1:0] AGE_MAX = '1;

    typedef enum logic {IDLE, WALK} state_t;

    state_t state_q, state_d;

    logic             ent_valid [N];
    logic [VPN_W-1:0] ent_vpn   [N];
    logic [PPN_W-1:0] ent_ppn   [N];
    logic             ent_wr    [N];
    logic [AGE_W-1:0] ent_age   [N];

    logic             resp_valid_q, resp_valid_d;
    logic [PA_W-1:0]  resp_paddr_q, resp_paddr_d;
    logic             resp_fault_q, resp_fault_d;
    logic             stall_q, stall_d;
    logic             ptw_req_q, ptw_req_d;
    logic [VPN_W-1:0] ptw_vpn_q, ptw_vpn_d;
    logic [OFF_W-1:0] walk_off;
    logic             walk_write;

    logic [VPN_W-1:0] req_vpn;
    logic [OFF_W-1:0] req_off;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             have_free;
    logic [IDX_W-1:0] free_idx;
    logic [IDX_W-1:0] old_idx;
    logic [AGE_W-1:0] old_age;
    logic [IDX_W-1:0] victim;
    logic             start_walk;
    logic             touch;
    logic [IDX_W-1:0] touch_idx;
    logic             refill;

    assign req_vpn = bus.req_vaddr[VA_W-1:OFF_W];
    assign req_off = bus.req_vaddr[OFF_W-1:0];

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_paddr = resp_paddr_q;
    assign bus.resp_fault = resp_fault_q;
    assign bus.stall      = stall_q;
    assign bus.ptw_req    = ptw_req_q;
    assign bus.ptw_vpn    = ptw_vpn_q;
    assign dbg_state      = (state_q == WALK);

    // Scanning downward leaves the lowest matching index selected.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (ent_valid[i] && (ent_vpn[i] == req_vpn)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    // Victim: lowest free slot, otherwise the oldest entry (strict > keeps lowest on ties).
    always_comb begin
        have_free = 1'b0;
        free_idx  = '0;
        old_idx   = '0;
        old_age   = ent_age[0];
        for (int i = N - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                have_free = 1'b1;
                free_idx  = IDX_W'(i);
            end
        end
        for (int i = 1; i < N; i++) begin
            if (ent_age[i] > old_age) begin
                old_age = ent_age[i];
                old_idx = IDX_W'(i);
            end
        end
        victim = have_free ? free_idx : old_idx;
    end

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        resp_paddr_d = resp_paddr_q;
        resp_fault_d = 1'b0;
        stall_d      = stall_q;
        ptw_req_d    = ptw_req_q;
        ptw_vpn_d    = ptw_vpn_q;
        start_walk   = 1'b0;
        touch        = 1'b0;
        touch_idx    = hit_idx;
        refill       = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    if (mode) begin
                        resp_valid_d = 1'b1;
                        resp_paddr_d = bus.req_vaddr[PA_W-1:0];
                    end else if (hit) begin
                        resp_valid_d = 1'b1;
                        resp_paddr_d = {ent_ppn[hit_idx], req_off};
                        resp_fault_d = bus.req_write & ~ent_wr[hit_idx];
                        touch        = 1'b1;
                    end else begin
                        state_d    = WALK;
                        stall_d    = 1'b1;
                        ptw_req_d  = 1'b1;
                        ptw_vpn_d  = req_vpn;
                        start_walk = 1'b1;
                    end
                end
            end
            WALK: begin
                if (bus.ptw_ack) begin
                    state_d      = IDLE;
                    stall_d      = 1'b0;
                    ptw_req_d    = 1'b0;
                    resp_valid_d = 1'b1;
                    if (bus.ptw_fault) begin
                        resp_fault_d = 1'b1;
                        resp_paddr_d = '0;
                    end else begin
                        refill       = 1'b1;
                        touch        = 1'b1;
                        touch_idx    = victim;
                        resp_paddr_d = {bus.ptw_ppn, walk_off};
                        resp_fault_d = walk_write & ~bus.ptw_writable;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_paddr_q <= '0;
            resp_fault_q <= 1'b0;
            stall_q      <= 1'b0;
            ptw_req_q    <= 1'b0;
            ptw_vpn_q    <= '0;
            walk_off     <= '0;
            walk_write   <= 1'b0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= resp_valid_d;
            resp_paddr_q <= resp_paddr_d;
            resp_fault_q <= resp_fault_d;
            stall_q      <= stall_d;
            ptw_req_q    <= ptw_req_d;
            ptw_vpn_q    <= ptw_vpn_d;
            if (start_walk) begin
                walk_off   <= req_off;
                walk_write <= bus.req_write;
            end
        end
    end

    // Flush is applied first so a same-cycle refill of the victim overrides it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                ent_valid[i] <= 1'b0;
                ent_vpn[i]   <= '0;
                ent_ppn[i]   <= '0;
                ent_wr[i]    <= 1'b0;
                ent_age[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (flush_all) begin
                    ent_valid[i] <= 1'b0;
                end else if (flush_vpn_en && (ent_vpn[i] == flush_vpn)) begin
                    ent_valid[i] <= 1'b0;
                end
                if (touch) begin
                    if (IDX_W'(i) == touch_idx) begin
                        ent_age[i] <= '0;
                    end else if (ent_valid[i] && (ent_age[i] != AGE_MAX)) begin
                        ent_age[i] <= ent_age[i] + 1'b1;
                    end
                end
                if (refill && (IDX_W'(i) == victim)) begin
                    ent_valid[i] <= 1'b1;
                    ent_vpn[i]   <= ptw_vpn_q;
                    ent_ppn[i]   <= bus.ptw_ppn;
                    ent_wr[i]    <= bus.ptw_writable;
                end
            end
        end
    end
endmodule

// File: tb/tb_tlb_walk.sv
// Directed bench for tlb_walk (4-entry build): miss/refill, hits, write faults,
// LRU replacement, walk faults, supervisor bypass, flushes and reset mid-walk.
module tb_tlb_walk;
    logic        clk;
    logic        rst;
    logic        mode;
    logic        flush_all;
    logic        flush_vpn_en;
    logic [19:0] flush_vpn;
    logic        dbg_state;
    int          n_checks;
    int          n_fail;

    tlb_walk_if #(.VA_W(32), .PA_W(20), .OFF_W(12)) bus ();

    tlb_walk #(.N(4), .VA_W(32), .PA_W(20), .OFF_W(12), .AGE_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .flush_all    (flush_all),
        .flush_vpn_en (flush_vpn_en),
        .flush_vpn    (flush_vpn),
        .bus          (bus),
        .dbg_state    (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic lookup(input logic [31:0] vaddr, input logic write);
        bus.req_valid = 1'b1;
        bus.req_vaddr = vaddr;
        bus.req_write = write;
        step();
        bus.req_valid = 1'b0;
    endtask

    task automatic expect_hit(input string tag, input logic [31:0] vaddr, input logic write,
                              input logic [31:0] paddr, input logic fault);
        lookup(vaddr, write);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd1);
        chk({tag, "_paddr"}, 32'(bus.resp_paddr), paddr);
        chk({tag, "_fault"}, 32'(bus.resp_fault), 32'(fault));
        chk({tag, "_stall"}, 32'(bus.stall), 32'd0);
    endtask

    task automatic expect_miss(input string tag, input logic [31:0] vaddr, input logic write);
        lookup(vaddr, write);
        chk({tag, "_valid"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_stall"}, 32'(bus.stall), 32'd1);
        chk({tag, "_ptwreq"}, 32'(bus.ptw_req), 32'd1);
        chk({tag, "_ptwvpn"}, 32'(bus.ptw_vpn), 32'(vaddr[31:12]));
    endtask

    task automatic ack(input logic [7:0] ppn, input logic writable, input logic fault);
        bus.ptw_ack      = 1'b1;
        bus.ptw_ppn      = ppn;
        bus.ptw_writable = writable;
        bus.ptw_fault    = fault;
        step();
        bus.ptw_ack = 1'b0;
        chk("ack_stall", 32'(bus.stall), 32'd0);
        chk("ack_ptwreq", 32'(bus.ptw_req), 32'd0);
        chk("ack_valid", 32'(bus.resp_valid), 32'd1);
    endtask

    task automatic fill(input logic [19:0] vpn, input logic [7:0] ppn);
        expect_miss("fill", {vpn, 12'h0A0}, 1'b0);
        ack(ppn, 1'b1, 1'b0);
        chk("fill_paddr", 32'(bus.resp_paddr), {12'h0, ppn, 12'h0A0});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
    endtask

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        rst              = 1'b1;
        mode             = 1'b0;
        flush_all        = 1'b0;
        flush_vpn_en     = 1'b0;
        flush_vpn        = '0;
        bus.req_valid    = 1'b0;
        bus.req_vaddr    = '0;
        bus.req_write    = 1'b0;
        bus.ptw_ack      = 1'b0;
        bus.ptw_ppn      = '0;
        bus.ptw_writable = 1'b0;
        bus.ptw_fault    = 1'b0;
        do_reset();

        chk("rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_fault", 32'(bus.resp_fault), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_ptwreq", 32'(bus.ptw_req), 32'd0);
        chk("rst_paddr", 32'(bus.resp_paddr), 32'd0);
        chk("rst_ptwvpn", 32'(bus.ptw_vpn), 32'd0);

        // First miss, walk held for three cycles, then refill.
        expect_miss("miss12", 32'h0001_2345, 1'b0);
        chk("walk_state", 32'(dbg_state), 32'd1);
        step();
        chk("hold1_ptwreq", 32'(bus.ptw_req), 32'd1);
        step();
        chk("hold2_stall", 32'(bus.stall), 32'd1);
        ack(8'h4A, 1'b1, 1'b0);
        chk("refill_paddr", 32'(bus.resp_paddr), 32'h4A345);
        chk("refill_fault", 32'(bus.resp_fault), 32'd0);
        chk("idle_state", 32'(dbg_state), 32'd0);

        // Back-to-back hits, then an idle cycle.
        expect_hit("hit12fff", 32'h0001_2FFF, 1'b0, 32'h4AFFF, 1'b0);
        chk("hit_noptw", 32'(bus.ptw_req), 32'd0);
        expect_hit("st12", 32'h0001_2010, 1'b1, 32'h4A010, 1'b0);
        step();
        chk("idle_valid", 32'(bus.resp_valid), 32'd0);

        // Store miss onto a read-only page faults, as do later stores to it.
        expect_miss("miss34", 32'h0003_4ABC, 1'b1);
        ack(8'h11, 1'b0, 1'b0);
        chk("ro_fill_paddr", 32'(bus.resp_paddr), 32'h11ABC);
        chk("ro_fill_fault", 32'(bus.resp_fault), 32'd1);
        expect_hit("ld34", 32'h0003_4000, 1'b0, 32'h11000, 1'b0);
        expect_hit("st34", 32'h0003_4004, 1'b1, 32'h11004, 1'b1);

        // LRU: fill 1..4, touch 2,3,4, so VPN 1 is evicted by VPN 5.
        do_reset();
        fill(20'd1, 8'h81);
        fill(20'd2, 8'h82);
        fill(20'd3, 8'h83);
        fill(20'd4, 8'h84);
        expect_hit("lru_h2", 32'h0000_2123, 1'b0, 32'h82123, 1'b0);
        expect_hit("lru_h3", 32'h0000_3123, 1'b0, 32'h83123, 1'b0);
        expect_hit("lru_h4", 32'h0000_4123, 1'b0, 32'h84123, 1'b0);
        fill(20'd5, 8'h85);
        expect_hit("lru_k2", 32'h0000_2456, 1'b0, 32'h82456, 1'b0);
        expect_hit("lru_k3", 32'h0000_3456, 1'b0, 32'h83456, 1'b0);
        expect_hit("lru_k4", 32'h0000_4456, 1'b0, 32'h84456, 1'b0);
        expect_hit("lru_k5", 32'h0000_5456, 1'b0, 32'h85456, 1'b0);

        // VPN 1 evicted; its walk faults and nothing is written.
        expect_miss("lru_m1", 32'h0000_1777, 1'b0);
        ack(8'hEE, 1'b1, 1'b1);
        chk("pf_fault", 32'(bus.resp_fault), 32'd1);
        chk("pf_paddr", 32'(bus.resp_paddr), 32'd0);
        expect_miss("pf_again", 32'h0000_1777, 1'b0);
        ack(8'hEE, 1'b1, 1'b1);
        expect_hit("pf_k2", 32'h0000_2001, 1'b0, 32'h82001, 1'b0);

        // Supervisor bypass.
        mode = 1'b1;
        expect_hit("sup", 32'hABCD_E123, 1'b1, 32'hDE123, 1'b0);
        chk("sup_noptw", 32'(bus.ptw_req), 32'd0);
        mode = 1'b0;

        // Per-VPN flush, then flush_all racing a lookup that still hits.
        flush_vpn_en = 1'b1;
        flush_vpn    = 20'd2;
        step();
        flush_vpn_en = 1'b0;
        expect_miss("fl_m2", 32'h0000_2000, 1'b0);
        ack(8'h00, 1'b0, 1'b1);
        expect_hit("fl_k3", 32'h0000_3010, 1'b0, 32'h83010, 1'b0);
        flush_all = 1'b1;
        expect_hit("fl_same", 32'h0000_3020, 1'b0, 32'h83020, 1'b0);
        flush_all = 1'b0;
        expect_miss("fl_m3", 32'h0000_3020, 1'b0);
        ack(8'h00, 1'b0, 1'b1);
        expect_miss("fl_m5", 32'h0000_5020, 1'b0);
        ack(8'h00, 1'b0, 1'b1);

        // Reset during a walk drops the request at once; a stray ack is ignored.
        fill(20'd7, 8'h07);
        expect_miss("rw_m9", 32'h0000_9000, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        chk("rw_ptwreq", 32'(bus.ptw_req), 32'd0);
        chk("rw_stall", 32'(bus.stall), 32'd0);
        chk("rw_state", 32'(dbg_state), 32'd0);
        step();
        rst = 1'b0;
        bus.ptw_ack = 1'b1;
        bus.ptw_ppn = 8'h55;
        step();
        bus.ptw_ack = 1'b0;
        chk("rw_ack_valid", 32'(bus.resp_valid), 32'd0);
        chk("rw_ack_ptwreq", 32'(bus.ptw_req), 32'd0);
        expect_miss("rw_m7", 32'h0000_7000, 1'b0);
        ack(8'h00, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
